store_buffer_align: RTL and testbench

- Write-side counterpart of the WB load-extension path.
- Takes committed stores (SB/SH/SW) from the MEM stage and aligns the data into a 32-bit word lane.
- Generates byte strobes and flags misaligned stores (AdES).
- Queues aligned writes in a small FIFO that drains to the data cache over a valid/ready handshake.
- Reports load-after-store address conflicts so the pipeline can stall loads that would read stale data.

---
 rtl/store_buffer_align_pkg.sv | 21 ++
 rtl/store_buffer_align_if.sv | 38 +++
 rtl/store_buffer_align_align.sv | 40 ++++
 rtl/store_buffer_align.sv | 91 +++++++++
 tb/tb_store_buffer_align.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/store_buffer_align_pkg.sv
// Shared CPU store-path definitions: store size encoding, the buffered
// entry layout and the default buffer geometry.
package store_buffer_align_pkg;

    localparam int SB_DEPTH  = 4;
    localparam int SB_ADDR_W = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } StoreSize_t;

    typedef struct packed {
        logic [SB_ADDR_W-1:0] waddr;
        logic [3:0]           wstrb;
        logic [31:0]          wdata;
    } SBEntry_t;

endpackage

// File: rtl/store_buffer_align_if.sv
// Store-buffer bus bundle: MEM-stage store port, data-cache write port,
// load-conflict probe and occupancy status.
interface store_buffer_align_if #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
);
    // st_* and dc_w* are valid/ready pairs: a transfer happens on a rising
    // clk when valid and ready are both high; valid never waits on ready.
    logic                     st_valid;
    logic                     st_ready;
    logic [1:0]               st_size;
    logic [ADDR_W-1:0]        st_addr;
    logic [31:0]              st_wdata;
    logic                     st_ades;
    logic                     dc_wvalid;
    logic                     dc_wready;
    logic [ADDR_W-1:0]        dc_waddr;
    logic [3:0]               dc_wstrb;
    logic [31:0]              dc_wdata;
    logic                     ld_valid;
    logic [ADDR_W-1:0]        ld_addr;
    logic                     ld_conflict;
    logic                     sb_empty;
    logic [$clog2(DEPTH):0]   sb_count;

    modport master (
        output st_valid, st_size, st_addr, st_wdata, dc_wready, ld_valid, ld_addr,
        input  st_ready, st_ades, dc_wvalid, dc_waddr, dc_wstrb, dc_wdata,
               ld_conflict, sb_empty, sb_count
    );

    modport slave (
        input  st_valid, st_size, st_addr, st_wdata, dc_wready, ld_valid, ld_addr,
        output st_ready, st_ades, dc_wvalid, dc_waddr, dc_wstrb, dc_wdata,
               ld_conflict, sb_empty, sb_count
    );

endinterface

// File: rtl/store_buffer_align_align.sv
// Store lane alignment: size/offset to byte strobes, replicated lane data
// and the misaligned-address exception.
module store_align
    import store_buffer_align_pkg::*;
(
    input  logic        valid,
    input  StoreSize_t  size,
    input  logic [1:0]  offset,
    input  logic [31:0] data,
    output logic [3:0]  strb,
    output logic [31:0] lane_data,
    output logic        ades,
    output logic        rsvd
);

    always_comb begin
        strb      = 4'b0000;
        lane_data = 32'h0;
        ades      = 1'b0;
        rsvd      = 1'b0;
        case (size)
            SZ_BYTE: begin
                strb      = 4'b0001 << offset;
                lane_data = {4{data[7:0]}};
            end
            SZ_HALF: begin
                strb      = offset[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{data[15:0]}};
                ades      = valid & offset[0];
            end
            SZ_WORD: begin
                strb      = 4'b1111;
                lane_data = data;
                ades      = valid & (offset != 2'b00);
            end
            default: rsvd = 1'b1;
        endcase
    end

endmodule

// File: rtl/store_buffer_align.sv
// In-order store buffer: aligns committed stores, queues them and drains
// them to the data cache, flagging loads that hit a pending store word.
module store_buffer_align
    import store_buffer_align_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH,
    parameter int ADDR_W = SB_ADDR_W
) (
    input logic                clk,
    input logic                resetn,
    store_buffer_align_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [CW-1:0]     count;
    logic [DEPTH-1:0]  vld;
    SBEntry_t          mem [DEPTH];

    logic [3:0]        al_strb;
    logic [31:0]       al_data;
    logic              al_rsvd;
    logic              push, pop;
    logic              hit;
    logic [ADDR_W-1:0] ew;

    store_align u_align (
        .valid     (bus.st_valid),
        .size      (StoreSize_t'(bus.st_size)),
        .offset    (bus.st_addr[1:0]),
        .data      (bus.st_wdata),
        .strb      (al_strb),
        .lane_data (al_data),
        .ades      (bus.st_ades),
        .rsvd      (al_rsvd)
    );

    // Ready depends only on occupancy, keeping dc_wready off the store path.
    assign bus.st_ready  = (count != CW'(DEPTH));
    assign bus.dc_wvalid = (count != '0);
    assign bus.sb_empty  = (count == '0);
    assign bus.sb_count  = count;
    assign bus.dc_waddr  = ADDR_W'(mem[rd_ptr].waddr);
    assign bus.dc_wstrb  = mem[rd_ptr].wstrb;
    assign bus.dc_wdata  = mem[rd_ptr].wdata;

    assign push = bus.st_valid & bus.st_ready & ~bus.st_ades & ~al_rsvd;
    assign pop  = bus.dc_wvalid & bus.dc_wready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            vld    <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr].waddr <= SB_ADDR_W'({bus.st_addr[ADDR_W-1:2], 2'b00});
                mem[wr_ptr].wstrb <= al_strb;
                mem[wr_ptr].wdata <= al_data;
                vld[wr_ptr]       <= 1'b1;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) begin
                vld[rd_ptr] <= 1'b0;
                rd_ptr      <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Word-granular match; the entry being written this cycle is not yet valid.
    always_comb begin
        hit = 1'b0;
        ew  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ew = ADDR_W'(mem[i].waddr);
            if (vld[i] && (((ew ^ bus.ld_addr) >> 2) == '0)) hit = 1'b1;
        end
    end

    assign bus.ld_conflict = bus.ld_valid & hit;

endmodule

// File: tb/tb_store_buffer_align.sv
// Directed bench for store_buffer_align with a scoreboard on the cache port.
module tb_store_buffer_align;

    localparam int ADDR_W = 32;
    localparam int DEPTH  = 4;

    logic clk;
    logic resetn;
    int   compared;
    int   mismatched;
    logic [67:0] exp_q[$];

    store_buffer_align_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

    store_buffer_align #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [67:0] obs, input logic [67:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [67:0] exp_entry(input logic [1:0] sz, input logic [31:0] a,
                                              input logic [31:0] d);
        logic [3:0]  s;
        logic [31:0] w;
        case (sz)
            2'd0: begin s = 4'b0001 << a[1:0];            w = {4{d[7:0]}};  end
            2'd1: begin s = a[1] ? 4'b1100 : 4'b0011;     w = {2{d[15:0]}}; end
            default: begin s = 4'b1111;                   w = d;            end
        endcase
        return {a[31:2], 2'b00, s, w};
    endfunction

    // Scoreboard: every cache-side transfer pops the oldest expected entry.
    always @(negedge clk) begin
        if (resetn && bus.dc_wvalid && bus.dc_wready) begin
            compared++;
            assert (exp_q.size() != 0) else begin
                mismatched++;
                $error("FAIL unexpected_pop observed=%0h expected=none", bus.dc_waddr);
            end
            if (exp_q.size() != 0)
                check("dc_entry", {bus.dc_waddr, bus.dc_wstrb, bus.dc_wdata}, exp_q.pop_front());
        end
    end

    // Driver tasks: inputs change 2ns after a rising edge, checks on falling edges.
    task automatic realign();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                               input bit acc, input bit ades);
        bus.st_valid = 1'b1;
        bus.st_size  = sz;
        bus.st_addr  = a;
        bus.st_wdata = d;
        @(negedge clk);
        check("st_ades", 68'(bus.st_ades), 68'(ades));
        if (acc) exp_q.push_back(exp_entry(sz, a, d));
        realign();
        bus.st_valid = 1'b0;
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.sb_empty) break;
        end
        check("drain_empty", 68'(bus.sb_empty), 68'(1'b1));
        realign();
    endtask

    initial begin
        compared     = 0;
        mismatched   = 0;
        resetn       = 1'b0;
        bus.st_valid = 1'b0;
        bus.st_size  = 2'b00;
        bus.st_addr  = '0;
        bus.st_wdata = '0;
        bus.dc_wready = 1'b1;
        bus.ld_valid = 1'b0;
        bus.ld_addr  = '0;

        #3;
        check("rst_wvalid", 68'(bus.dc_wvalid), 68'(1'b0));
        check("rst_empty",  68'(bus.sb_empty),  68'(1'b1));
        check("rst_count",  68'(bus.sb_count),  68'(0));
        check("rst_ready",  68'(bus.st_ready),  68'(1'b1));
        check("rst_conf",   68'(bus.ld_conflict), 68'(1'b0));
        realign();
        resetn = 1'b1;
        realign();

        // Byte store at offset 3, visible the next cycle then drained.
        drive_store(2'd0, 32'h1000_0003, 32'h0000_00AB, 1'b1, 1'b0);
        @(negedge clk);
        check("sb_wvalid", 68'(bus.dc_wvalid), 68'(1'b1));
        realign();
        @(negedge clk);
        check("sb_empty_after", 68'(bus.sb_empty), 68'(1'b1));
        realign();

        // Halfword, misaligned halfword / word, reserved size.
        drive_store(2'd1, 32'h0000_2002, 32'h0000_1234, 1'b1, 1'b0);
        drive_store(2'd1, 32'h0000_2001, 32'h0000_5678, 1'b0, 1'b1);
        @(negedge clk);
        check("ades_count", 68'(bus.sb_count), 68'(0));
        realign();
        drive_store(2'd2, 32'h0000_2006, 32'hDEAD_BEEF, 1'b0, 1'b1);
        drive_store(2'd3, 32'h0000_2000, 32'hCAFE_F00D, 1'b0, 1'b0);
        @(negedge clk);
        check("rsvd_count", 68'(bus.sb_count), 68'(0));
        realign();

        // Fill to DEPTH with the cache stalled, then drain in order.
        bus.dc_wready = 1'b0;
        for (int i = 0; i < 4; i++)
            drive_store(2'd2, 32'h10 + 32'(i * 4), $urandom, 1'b1, 1'b0);
        @(negedge clk);
        check("full_count", 68'(bus.sb_count), 68'(4));
        check("full_ready", 68'(bus.st_ready), 68'(1'b0));
        realign();
        drive_store(2'd2, 32'h20, 32'h1111_2222, 1'b0, 1'b0);
        drive_store(2'd2, 32'h21, 32'h3333_4444, 1'b0, 1'b1);
        check("full_hold", 68'(bus.sb_count), 68'(4));
        bus.dc_wready = 1'b1;
        @(negedge clk);
        realign();
        @(negedge clk);
        check("ready_after_pop", 68'(bus.st_ready), 68'(1'b1));
        check("count_after_pop", 68'(bus.sb_count), 68'(3));
        realign();
        wait_empty();

        // Push and pop in the same cycle with two entries held.
        bus.dc_wready = 1'b0;
        drive_store(2'd0, 32'h0000_0041, 32'h0000_0077, 1'b1, 1'b0);
        drive_store(2'd1, 32'h0000_0046, 32'h0000_9ABC, 1'b1, 1'b0);
        bus.dc_wready = 1'b1;
        drive_store(2'd2, 32'h0000_0048, 32'h0BAD_F00D, 1'b1, 1'b0);
        @(negedge clk);
        check("pushpop_count", 68'(bus.sb_count), 68'(2));
        realign();
        wait_empty();

        // Ten random aligned stores through the buffer to wrap the pointers.
        for (int i = 0; i < 10; i++) begin
            logic [1:0]  sz;
            logic [31:0] off;
            sz  = 2'($urandom_range(0, 2));
            off = (sz == 2'd0) ? 32'($urandom_range(0, 3)) :
                  (sz == 2'd1) ? 32'(2 * $urandom_range(0, 1)) : 32'd0;
            drive_store(sz, 32'h5000 + 32'(i * 4) + off, $urandom, 1'b1, 1'b0);
        end
        wait_empty();

        // Load conflict probe.
        bus.dc_wready = 1'b0;
        bus.ld_valid  = 1'b1;
        bus.ld_addr   = 32'h0000_3004;
        bus.st_valid  = 1'b1;
        bus.st_size   = 2'd2;
        bus.st_addr   = 32'h0000_3004;
        bus.st_wdata  = 32'h0102_0304;
        @(negedge clk);
        check("ld_same_cycle_push", 68'(bus.ld_conflict), 68'(1'b0));
        exp_q.push_back(exp_entry(2'd2, 32'h0000_3004, 32'h0102_0304));
        realign();
        bus.st_valid = 1'b0;
        bus.ld_addr  = 32'h0000_3007;
        @(negedge clk);
        check("ld_hit_3007", 68'(bus.ld_conflict), 68'(1'b1));
        realign();
        bus.ld_addr = 32'h0000_3008;
        @(negedge clk);
        check("ld_miss_3008", 68'(bus.ld_conflict), 68'(1'b0));
        realign();
        bus.ld_addr   = 32'h0000_3004;
        bus.dc_wready = 1'b1;
        @(negedge clk);
        check("ld_hit_popping", 68'(bus.ld_conflict), 68'(1'b1));
        realign();
        @(negedge clk);
        check("ld_after_pop", 68'(bus.ld_conflict), 68'(1'b0));
        realign();
        bus.ld_valid = 1'b0;

        // Asynchronous reset with three entries pending.
        bus.dc_wready = 1'b0;
        for (int i = 0; i < 3; i++)
            drive_store(2'd2, 32'h0000_6000 + 32'(i * 4), $urandom, 1'b1, 1'b0);
        #1;
        resetn = 1'b0;
        #1;
        check("arst_wvalid", 68'(bus.dc_wvalid), 68'(1'b0));
        check("arst_count",  68'(bus.sb_count),  68'(0));
        check("arst_empty",  68'(bus.sb_empty),  68'(1'b1));
        exp_q.delete();
        realign();
        resetn        = 1'b1;
        bus.dc_wready = 1'b1;
        realign();
        drive_store(2'd2, 32'h0000_4000, 32'h89AB_CDEF, 1'b1, 1'b0);
        wait_empty();

        check("queue_drained", 68'(exp_q.size()), 68'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
